// File: rtl/ads_pkg.sv
// Shared types and default widths for the anomaly-detection sequencer slice.
package ads_pkg;

   typedef enum logic [2:0] {
      ST_UNCONF,
      ST_LOAD,
      ST_IDLE,
      ST_POP,
      ST_ISSUE,
      ST_WAIT
   } ads_state_t;

   localparam int unsigned ADS_DATA_W = 8;
   localparam int unsigned ADS_TREE_W = 256;
   localparam int unsigned ADS_CNT_W  = 16;

endpackage

// File: rtl/ads_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module ads_sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] q
);

   // Count up until all-ones, then hold; clear takes priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc && (q != '1)) begin
         q <= q + 1'b1;
      end
   end

endmodule

// File: rtl/ads_detect_sequencer.sv
// Sequencer between the sensor FIFO and the isolation-tree evaluator.
// Loads a tree image, then drains the FIFO one sample at a time with a
// pop / present / wait-for-verdict handshake and keeps saturating counts.
// Optional evaluator watchdog: define ADS_SEQ_TIMEOUT_EN.
module ads_detect_sequencer
   import ads_pkg::*;
#(
   parameter int unsigned DATA_W         = ADS_DATA_W,
   parameter int unsigned TREE_W         = ADS_TREE_W,
   parameter int unsigned CNT_W          = ADS_CNT_W,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_valid,
   input  logic [TREE_W-1:0] cfg_tree,
   output logic              cfg_ready,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              fifo_read_enable,
   output logic              eval_load_itree,
   output logic [TREE_W-1:0] eval_itree,
   output logic [DATA_W-1:0] eval_data,
   output logic              eval_data_valid,
   input  logic              eval_done,
   input  logic              eval_anomaly,
   input  logic              clear_counts,
   output logic              anomaly_detected,
   output logic [CNT_W-1:0]  sample_count,
   output logic [CNT_W-1:0]  anomaly_count,
   output logic              busy,
   output logic              timeout_err
);

   localparam int unsigned TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   ads_state_t state;
   ads_state_t state_nxt;
   logic       capture_tree;
   logic       verdict;
   logic       timeout_hit;
   logic       idle_like;

`ifdef ADS_SEQ_TIMEOUT_EN
   logic [TO_W-1:0] wait_cnt;
`endif

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_UNCONF;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and per-cycle strobes; a new image beats a pending pop in IDLE.
   always_comb begin
      state_nxt        = state;
      fifo_read_enable = 1'b0;
      capture_tree     = 1'b0;
      verdict          = 1'b0;
      timeout_hit      = 1'b0;
      case (state)
         ST_UNCONF: begin
            if (cfg_valid) begin
               capture_tree = 1'b1;
               state_nxt    = ST_LOAD;
            end
         end
         ST_LOAD: state_nxt = ST_IDLE;
         ST_IDLE: begin
            if (cfg_valid) begin
               capture_tree = 1'b1;
               state_nxt    = ST_LOAD;
            end else if (!fifo_empty) begin
               fifo_read_enable = 1'b1;
               state_nxt        = ST_POP;
            end
         end
         ST_POP:   state_nxt = ST_ISSUE;
         ST_ISSUE: state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (eval_done) begin
               verdict   = 1'b1;
               state_nxt = ST_IDLE;
            end
`ifdef ADS_SEQ_TIMEOUT_EN
            else if (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
               timeout_hit = 1'b1;
               state_nxt   = ST_IDLE;
            end
`endif
         end
         default: state_nxt = ST_UNCONF;
      endcase
   end

   // Status outputs decoded from state; cfg_ready is held low while in reset.
   always_comb begin
      idle_like       = (state == ST_UNCONF) || (state == ST_IDLE);
      cfg_ready       = idle_like && !reset;
      busy            = !idle_like;
      eval_load_itree = (state == ST_LOAD);
      eval_data_valid = (state == ST_ISSUE);
   end

   // Tree image and sample holding registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         eval_itree <= '0;
         eval_data  <= '0;
      end else begin
         if (capture_tree) begin
            eval_itree <= cfg_tree;
         end
         if (state == ST_POP) begin
            eval_data <= fifo_data;
         end
      end
   end

   // One-cycle anomaly pulse following an anomalous verdict.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         anomaly_detected <= 1'b0;
      end else begin
         anomaly_detected <= verdict && eval_anomaly;
      end
   end

   ads_sat_counter #(.W(CNT_W)) u_sample_cnt (
      .clk (clk),
      .rst (reset),
      .inc (verdict),
      .clr (clear_counts),
      .q   (sample_count)
   );

   ads_sat_counter #(.W(CNT_W)) u_anomaly_cnt (
      .clk (clk),
      .rst (reset),
      .inc (verdict && eval_anomaly),
      .clr (clear_counts),
      .q   (anomaly_count)
   );

`ifdef ADS_SEQ_TIMEOUT_EN
   // Watchdog: counts WAIT cycles from zero on entry; sticky error on expiry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_cnt    <= '0;
         timeout_err <= 1'b0;
      end else begin
         wait_cnt <= (state == ST_WAIT) ? wait_cnt + 1'b1 : '0;
         if (clear_counts) begin
            timeout_err <= 1'b0;
         end else if (timeout_hit) begin
            timeout_err <= 1'b1;
         end
      end
   end
`else
   // No watchdog: WAIT is unbounded; the parameter stays referenced.
   logic unused_timeout;
   always_comb begin
      unused_timeout = timeout_hit ^ (^TO_W'(TIMEOUT_CYCLES));
      timeout_err    = 1'b0;
   end
`endif

endmodule
